// File: rtl/posit_encoder.sv
// Posit packing stage: serial regime emission, exponent/fraction pack, round-to-nearest-even, sign.
// Saturates to maxpos/minpos; NaR and zero bypass the serial path.
module posit_encoder #(
   parameter int N  = 32,
   parameter int ES = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          sign_in,
   input  logic [9:0]    scale_in,
   input  logic [63:0]   mant_in,
   input  logic          zero_in,
   input  logic          nar_in,
   output logic [N-1:0]  posit_out,
   output logic          busy,
   output logic          done
);
   // Working string: regime bits enter at the top, tail is {e, fraction, zero pad}
   localparam int W  = ES + 62 + N - 1;
   localparam int CW = $clog2(N);
   localparam logic signed [9:0] K_MAX = 10'(N - 2);
   localparam logic signed [9:0] K_MIN = -K_MAX;

   typedef enum logic [2:0] {IDLE, REGIME, PACK, ROUND, DONE_ST} state_t;

   state_t           r_state, w_next;
   logic             r_sign, r_run, r_guard, r_sticky;
   logic [CW-1:0]    r_cnt, r_last;
   logic [W-1:0]     r_work;
   logic [N-2:0]     r_body;
   logic [N-1:0]     r_out;

   logic signed [9:0] w_k;
   logic              w_mant_zero, w_sat_hi, w_sat_lo, w_fast, w_inc;
   logic [CW-1:0]     w_len_m1;
   logic [N-1:0]      w_fast_out, w_round_out;
   logic [N-2:0]      w_body_rnd;
   logic              w_unused;

   function automatic logic [N-1:0] apply_sign(input logic s, input logic [N-2:0] body);
      logic [N-1:0] v;
      v = {1'b0, body};
      return s ? (~v + N'(1)) : v;
   endfunction

   assign w_unused    = mant_in[63];
   assign w_k         = $signed(scale_in) >>> ES;
   assign w_mant_zero = (mant_in[62:0] == '0);
   assign w_sat_hi    = (w_k >= K_MAX);
   assign w_sat_lo    = (w_k < K_MIN);
   assign w_fast      = nar_in | zero_in | w_mant_zero | w_sat_hi | w_sat_lo;
   // Regime length minus one: k+1 for k >= 0, -k for k < 0
   assign w_len_m1    = w_k[9] ? (~w_k[CW-1:0] + CW'(1)) : (w_k[CW-1:0] + CW'(1));

   always_comb begin
      w_fast_out = '0;
      if (nar_in)
         w_fast_out = {1'b1, {(N-1){1'b0}}};
      else if (zero_in || w_mant_zero)
         w_fast_out = '0;
      else if (w_sat_hi)
         w_fast_out = apply_sign(sign_in, {(N-1){1'b1}});
      else if (w_sat_lo)
         w_fast_out = apply_sign(sign_in, {{(N-2){1'b0}}, 1'b1});
   end

   // An all-ones body is maxpos and must not wrap
   assign w_inc       = r_guard & (r_body[0] | r_sticky) & ~(&r_body);
   assign w_body_rnd  = r_body + {{(N-2){1'b0}}, w_inc};
   assign w_round_out = apply_sign(r_sign, w_body_rnd);

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = w_fast ? DONE_ST : REGIME;
         REGIME:  if (r_cnt == r_last) w_next = PACK;
         PACK:    w_next = ROUND;
         ROUND:   w_next = DONE_ST;
         DONE_ST: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sign   <= 1'b0;
         r_run    <= 1'b0;
         r_guard  <= 1'b0;
         r_sticky <= 1'b0;
         r_cnt    <= '0;
         r_last   <= '0;
         r_work   <= '0;
         r_body   <= '0;
         r_out    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sign <= sign_in;
                  r_run  <= ~w_k[9];
                  r_last <= w_len_m1;
                  r_cnt  <= '0;
                  r_work <= {scale_in[ES-1:0], mant_in[61:0], {(N-1){1'b0}}};
                  if (w_fast)
                     r_out <= w_fast_out;
               end
            end
            REGIME: begin
               // Right shift: terminator goes in first so it lands just above the tail
               r_work <= {(r_cnt == '0) ? ~r_run : r_run, r_work[W-1:1]};
               r_cnt  <= r_cnt + CW'(1);
            end
            PACK: begin
               r_body   <= r_work[W-1 -: N-1];
               r_guard  <= r_work[W-N];
               r_sticky <= |r_work[W-N-1:0];
            end
            ROUND:   r_out <= w_round_out;
            default: ;
         endcase
      end
   end

   assign posit_out = r_out;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE_ST);
endmodule
